conv_seq_ctrl: RTL and testbench

Sequencer for the convolution datapath: on a start request it walks NUM_TAPS input/weight word pairs out of a shared tap memory, drives datap_sel so the datapath captures each pair, and accumulates the returned 16-bit products into a signed sum. It sits between the top-level control/host interface and the datapath plus its input/weight memories, and returns one accumulated result per start with a done pulse.

---
 rtl/conv_seq_ctrl.sv | 108 ++++++++++
 tb/tb_conv_seq_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_seq_ctrl.sv
// Convolution sequencer: reads NUM_TAPS tap pairs, strobes the datapath, accumulates RMat products.
// Done in cycle NUM_TAPS+4 after start; optional SATURATE_EN macro selects clamping accumulation plus sat_flag.
module conv_seq_ctrl #(
  parameter int NUM_TAPS = 9,
  parameter int ADDR_W   = 4,
  parameter int ACC_W    = 24
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              datap_sel,
  input  logic [15:0]       rmat,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  acc_out
`ifdef SATURATE_EN
  ,
  output logic              sat_flag
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(NUM_TAPS - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] tap_cnt;
  logic [2:0]        vld_pipe;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_nxt;
  logic [ACC_W-1:0]  rmat_ext;
  logic              accept;

  assign accept    = (state == IDLE) && start;
  assign rd_addr   = tap_cnt;
  assign datap_sel = vld_pipe[0];
  assign acc_out   = acc;
  assign rmat_ext  = ACC_W'($signed(rmat));

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        rd_en = 1'b1;
        busy  = 1'b1;
        if (tap_cnt == LAST_TAP) state_nxt = DRAIN;
      end
      // Leave once nothing is left upstream of stage 3: the last product lands this cycle.
      DRAIN: begin
        busy = 1'b1;
        if (vld_pipe[1:0] == 2'b00) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SATURATE_EN
  logic [ACC_W:0] sum_wide;
  logic           clamp;

  assign sum_wide = {acc[ACC_W-1], acc} + {rmat_ext[ACC_W-1], rmat_ext};
  assign clamp    = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];

  always_comb begin
    acc_nxt = sum_wide[ACC_W-1:0];
    if (clamp) acc_nxt = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end

  always_ff @(posedge clock) begin
    if (!reset)                    sat_flag <= 1'b0;
    else if (accept)               sat_flag <= 1'b0;
    else if (vld_pipe[2] && clamp) sat_flag <= 1'b1;
  end
`else
  assign acc_nxt = acc + rmat_ext;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      tap_cnt  <= '0;
      vld_pipe <= '0;
      acc      <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1:0], rd_en};
      if (accept)     tap_cnt <= '0;
      else if (rd_en) tap_cnt <= (tap_cnt == LAST_TAP) ? '0 : tap_cnt + 1'b1;
      // rmat is only meaningful while stage 3 is set.
      if (accept)           acc <= '0;
      else if (vld_pipe[2]) acc <= acc_nxt;
    end
  end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl: cycle-level reference model plus hand-computed result checks.
// Second instance (16 taps, 16-bit accumulator) exercises overflow in wrap or SATURATE_EN builds.
module tb_conv_seq_ctrl;

  localparam int N    = 9;
  localparam int AW   = 4;
  localparam int ACC  = 24;
  localparam int N2   = 16;
  localparam int ACC2 = 16;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic            reset, start, rd_en, datap_sel, busy, done;
  logic [AW-1:0]   rd_addr;
  logic [15:0]     rmat;
  logic [ACC-1:0]  acc_out;
  logic            reset2, start2, rd_en2, sel2, busy2, done2;
  logic [AW-1:0]   rd_addr2;
  logic [15:0]     rmat2;
  logic [ACC2-1:0] acc_out2;
`ifdef SATURATE_EN
  logic            sat_flag, sat_flag2;
`endif

  conv_seq_ctrl #(.NUM_TAPS(N), .ADDR_W(AW), .ACC_W(ACC)) dut (
    .clock(clock), .reset(reset), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
    .datap_sel(datap_sel), .rmat(rmat), .busy(busy), .done(done), .acc_out(acc_out)
`ifdef SATURATE_EN
    , .sat_flag(sat_flag)
`endif
  );

  conv_seq_ctrl #(.NUM_TAPS(N2), .ADDR_W(AW), .ACC_W(ACC2)) dut_s (
    .clock(clock), .reset(reset2), .start(start2), .rd_en(rd_en2), .rd_addr(rd_addr2),
    .datap_sel(sel2), .rmat(rmat2), .busy(busy2), .done(done2), .acc_out(acc_out2)
`ifdef SATURATE_EN
    , .sat_flag(sat_flag2)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Tap values returned by the datapath for each stimulus mode.
  int mode = 0;
  function automatic logic [15:0] tap_val(input int m, input int k);
    case (m)
      0:       return 16'(k + 1);
      1:       return 16'hFFFD;
      default: return 16'h7FFF;
    endcase
  endfunction

  // Memory + datapath environment: garbage on rmat whenever no valid product is present.
  logic [AW-1:0] mem_q, opnd;
  logic          opnd_v = 1'b0;
  logic          opnd_v2 = 1'b0;
  always @(posedge clock) begin
    if (rd_en) mem_q <= rd_addr;
    if (datap_sel) opnd <= mem_q;
    opnd_v  <= datap_sel;
    rmat    <= opnd_v ? tap_val(mode, int'(opnd)) : 16'hA5A5;
    opnd_v2 <= sel2;
    rmat2   <= opnd_v2 ? 16'h7FFF : 16'hA5A5;
  end

  // Reference model: a run accepted in cycle t0 reads in t0+1..t0+N, strobes in t0+2..t0+N+1,
  // is busy through t0+N+3 and finishes with done in t0+N+4.
  int             cyc = 0;
  int             t0  = 0;
  bit             active = 1'b0;
  bit             armed  = 1'b0;
  logic [ACC-1:0] final_acc = '0;
  logic [ACC-1:0] hold_acc  = '0;

  function automatic logic [ACC-1:0] model_sum(input int m);
    longint s = 0;
    for (int k = 0; k < N; k++) s += longint'($signed(tap_val(m, k)));
    return ACC'(s);
  endfunction

  always @(posedge clock) begin
    if (!reset) begin
      active   = 1'b0;
      hold_acc = '0;
      armed    = 1'b1;
    end else if (!active) begin
      if (start) begin
        active    = 1'b1;
        t0        = cyc;
        final_acc = model_sum(mode);
      end
    end else if (cyc - t0 == N + 4) begin
      active   = 1'b0;
      hold_acc = final_acc;
    end
    cyc++;
  end

  always @(negedge clock) begin : compare
    int r;
    bit ex_rd;
    if (armed) begin
      r     = cyc - t0;
      ex_rd = active && r >= 1 && r <= N;
      check("rd_en", rd_en, ex_rd);
      if (ex_rd) check("rd_addr", rd_addr, 64'(r - 1));
      check("datap_sel", datap_sel, active && r >= 2 && r <= N + 1);
      check("busy", busy, active && r >= 1 && r <= N + 3);
      check("done", done, active && r == N + 4);
      if (!active)         check("acc_held", acc_out, hold_acc);
      else if (r == N + 4) check("acc_done", acc_out, final_acc);
`ifdef SATURATE_EN
      check("sat_flag", sat_flag, 1'b0);
`endif
    end
  end

  int sel_cnt  = 0;
  int done_cnt = 0;
  always @(negedge clock) begin
    sel_cnt  <= sel_cnt + int'(datap_sel);
    done_cnt <= done_cnt + int'(done);
  end

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic run_one(output int lat);
    int l;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(l);
    lat = l + 1;
  endtask

  initial begin
    int lat, g;
    reset  = 1'b0;
    start  = 1'b0;
    reset2 = 1'b0;
    start2 = 1'b0;
    repeat (2) @(negedge clock);
    check("reset_rd_en", rd_en, 1'b0);
    check("reset_acc", acc_out, 0);
    reset  = 1'b1;
    reset2 = 1'b1;
    repeat (20) @(negedge clock);

    // Basic run: products 1..9.
    mode = 0;
    sel_cnt = 0;
    run_one(lat);
    check("done_latency", lat, 13);
    check("acc_basic", acc_out, 24'd45);
    @(negedge clock);
    check("sel_count", sel_cnt, 9);

    // All products -3.
    mode = 1;
    run_one(lat);
    check("acc_signed", acc_out, 24'hFFFFE5);
    @(negedge clock);

    // Start pulses during RUN and DRAIN are ignored.
    mode = 0;
    done_cnt = 0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (6) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (20) @(negedge clock);
    check("single_done", done_cnt, 1);
    check("acc_ignored_start", acc_out, 24'd45);

    // Start held high: next run begins after exactly one idle cycle.
    start = 1'b1;
    @(negedge clock);
    wait_done(lat);
    g = 0;
    do begin
      @(negedge clock);
      g++;
    end while (!rd_en && g < 10);
    check("b2b_gap", g, 2);
    start = 1'b0;
    wait_done(lat);
    check("acc_b2b", acc_out, 24'd45);
    @(negedge clock);

    // Reset in cycle 5 of a run aborts it silently.
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    check("abort_rd_en", rd_en, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_acc", acc_out, 0);
    done_cnt = 0;
    repeat (20) @(negedge clock);
    check("abort_no_done", done_cnt, 0);
    run_one(lat);
    check("acc_after_abort", acc_out, 24'd45);

    // Overflow instance: sixteen products of 0x7FFF into a 16-bit accumulator.
    @(negedge clock);
    start2 = 1'b1;
    @(negedge clock);
    start2 = 1'b0;
    lat = 1;
    while (!done2 && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    check("sat_done_latency", lat, 20);
`ifdef SATURATE_EN
    check("acc_saturated", acc_out2, 16'h7FFF);
    check("sat_flag_set", sat_flag2, 1'b1);
`else
    check("acc_wrapped", acc_out2, 16'hFFF0);
`endif
    repeat (3) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
